// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one pipelined CORDIC sin/cos core
//
// Purpose: grants one requester per cycle and issues its phase to the CORDIC core.
// A {valid, tag} shift register that matches the core latency returns each result
// to the requester that issued it, as a one-cycle one-hot pulse.
// Optional feature macro: CORDIC_ARB_ANGLE_WRAP_EN. When it is defined, the issue
// stage applies a single +/-2*pi correction to the phase.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready per-requester handshake (ready is one-hot or zero)
//   i_req_phase             N_REQ x 18-bit signed Q5.13 angles
//   o_resp_valid            one-hot result pulse
//   o_resp_sincos           {sin, cos}, Q2.14 each, shared by all requesters
//   o_cordic_phase_valid/o_cordic_phase   to core s_axis_phase
//   i_cordic_dout_valid/i_cordic_dout     from core m_axis_dout
//   o_seq_err               sticky: core output valid disagreed with the tag pipeline
module cordic_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [N_REQ*18-1:0]  i_req_phase,
  output logic [N_REQ-1:0]     o_resp_valid,
  output logic [31:0]          o_resp_sincos,
  output logic                 o_cordic_phase_valid,
  output logic [15:0]          o_cordic_phase,
  input  logic                 i_cordic_dout_valid,
  input  logic [31:0]          i_cordic_dout,
  output logic                 o_seq_err
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [TAG_W-1:0]   r_rr_ptr;
  logic               r_issue_valid;
  logic [15:0]        r_issue_phase;
  logic [TAG_W-1:0]   r_issue_tag;
  logic [LATENCY-1:0] r_tp_valid;
  logic [TAG_W-1:0]   r_tp_tag [LATENCY];
  logic [N_REQ-1:0]   r_resp_valid;
  logic [31:0]        r_resp_sincos;
  logic               r_seq_err;
  logic [CNT_W-1:0]   r_arm_cnt;

  logic               w_grant;
  logic [TAG_W-1:0]   w_grant_idx;
  logic [TAG_W:0]     w_sum;
  logic signed [17:0] w_phase_sel;
  logic [15:0]        w_phase_corr;
  logic               w_unused;
  logic               w_armed;

  // Scan from the highest offset down to offset 0, so the requester nearest
  // rr_ptr is the last assignment and wins.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
      if (w_sum >= (TAG_W+1)'(N_REQ)) w_sum = w_sum - (TAG_W+1)'(N_REQ);
      if (i_req_valid[w_sum[TAG_W-1:0]]) begin
        w_grant     = 1'b1;
        w_grant_idx = w_sum[TAG_W-1:0];
      end
    end
    if (i_rst) w_grant = 1'b0;
  end

  assign o_req_ready = w_grant ? (N_REQ'(1) << w_grant_idx) : '0;
  assign w_phase_sel = i_req_phase[18*w_grant_idx +: 18];

`ifdef CORDIC_ARB_ANGLE_WRAP_EN
  localparam logic signed [17:0] PI     = 18'sh06487;
  localparam logic signed [17:0] TWO_PI = 18'sh0C90E;
  logic signed [17:0] w_phase_wrapped;

  always_comb begin
    if (w_phase_sel > PI)       w_phase_wrapped = w_phase_sel - TWO_PI;
    else if (w_phase_sel < -PI) w_phase_wrapped = w_phase_sel + TWO_PI;
    else                        w_phase_wrapped = w_phase_sel;
  end
  assign w_phase_corr = w_phase_wrapped[15:0];
  assign w_unused     = ^w_phase_wrapped[17:16];
`else
  assign w_phase_corr = w_phase_sel[15:0];
  assign w_unused     = ^w_phase_sel[17:16];
`endif

  // The core keeps emitting results for phases issued before a reset. Checking
  // stays disarmed until those have drained.
  assign w_armed = (r_arm_cnt == CNT_W'(LATENCY));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr      <= '0;
      r_issue_valid <= 1'b0;
      r_issue_phase <= '0;
      r_issue_tag   <= '0;
      r_tp_valid    <= '0;
      r_resp_valid  <= '0;
      r_resp_sincos <= '0;
      r_seq_err     <= 1'b0;
      r_arm_cnt     <= '0;
    end else begin
      r_issue_valid <= w_grant;
      if (w_grant) begin
        r_rr_ptr      <= (w_grant_idx == TAG_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_issue_phase <= w_phase_corr;
        r_issue_tag   <= w_grant_idx;
      end
      r_tp_valid <= {r_tp_valid[LATENCY-2:0], r_issue_valid};
      if (r_tp_valid[LATENCY-1]) begin
        r_resp_sincos <= i_cordic_dout;
        r_resp_valid  <= N_REQ'(1) << r_tp_tag[LATENCY-1];
      end else begin
        r_resp_valid  <= '0;
      end
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
      if (w_armed && (i_cordic_dout_valid != r_tp_valid[LATENCY-1])) r_seq_err <= 1'b1;
    end
  end

  // Tags are qualified by r_tp_valid, so they need no reset.
  always_ff @(posedge i_clk) begin
    r_tp_tag[0] <= r_issue_tag;
    for (int i = 1; i < LATENCY; i++) r_tp_tag[i] <= r_tp_tag[i-1];
  end

  assign o_resp_valid         = r_resp_valid;
  assign o_resp_sincos        = r_resp_sincos;
  assign o_cordic_phase_valid = r_issue_valid;
  assign o_cordic_phase       = r_issue_phase;
  assign o_seq_err            = r_seq_err;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - scoreboard bench for cordic_arbiter with a latency-matched core model
module tb_cordic_arbiter;
  localparam int N   = 4;
  localparam int LAT = 20;

`ifdef CORDIC_ARB_ANGLE_WRAP_EN
  localparam logic [15:0] EXP_POS = 16'h06F2;
  localparam logic [15:0] EXP_NEG = 16'hF90E;
`else
  localparam logic [15:0] EXP_POS = 16'hD000;
  localparam logic [15:0] EXP_NEG = 16'h3000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*18-1:0] req_phase;
  logic [N-1:0]  resp_valid;
  logic [31:0]   resp_sincos;
  logic          cordic_phase_valid;
  logic [15:0]   cordic_phase;
  logic          dout_valid;
  logic [31:0]   dout;
  logic          seq_err;

  cordic_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_phase(req_phase),
    .o_resp_valid(resp_valid), .o_resp_sincos(resp_sincos),
    .o_cordic_phase_valid(cordic_phase_valid), .o_cordic_phase(cordic_phase),
    .i_cordic_dout_valid(dout_valid), .i_cordic_dout(dout),
    .o_seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] core_fn(input logic [15:0] p);
    if (p == 16'h0000) return {16'h0000, 16'h4000};
    return {p ^ 16'h5A5A, ~p};
  endfunction

  function automatic logic [15:0] wrap_model(input logic [17:0] p);
    logic signed [17:0] s;
    s = p;
`ifdef CORDIC_ARB_ANGLE_WRAP_EN
    if (s > 18'sd25735)       s = s - 18'sd51470;
    else if (s < -18'sd25735) s = s + 18'sd51470;
`endif
    return s[15:0];
  endfunction

  // Core model: pure LATENCY-cycle delay line; not reset, like the real core.
  logic [LAT-1:0] cm_v = '0;
  logic [15:0]    cm_p [LAT];
  logic           force_dv = 1'b0;
  always @(posedge clk) begin
    cm_v    <= {cm_v[LAT-2:0], cordic_phase_valid};
    cm_p[0] <= cordic_phase;
    for (int i = 1; i < LAT; i++) cm_p[i] <= cm_p[i-1];
  end
  assign dout_valid = cm_v[LAT-1] | force_dv;
  assign dout       = core_fn(cm_p[LAT-1]);

  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [15:0] ph; int due; } iss_t;
  typedef struct { logic [N-1:0] oh; logic [31:0] sc; int due; } resp_t;
  iss_t  exp_iss[$];
  resp_t exp_resp[$];
  iss_t  sb_iss, mon_iss;
  resp_t sb_resp, mon_resp;
  int    resp2_cnt = 0;
  int    resp_any_cnt = 0;

  // Scoreboard producer: every completed transfer pushes its expected issue and response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_iss.ph   = wrap_model(req_phase[18*i +: 18]);
          sb_iss.due  = cyc + 1;
          sb_resp.oh  = N'(1) << i;
          sb_resp.sc  = core_fn(sb_iss.ph);
          sb_resp.due = cyc + LAT + 2;
          exp_iss.push_back(sb_iss);
          exp_resp.push_back(sb_resp);
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queue heads.
  always @(negedge clk) begin
    if (!rst) begin
      if (cordic_phase_valid) begin
        if (exp_iss.size() == 0) chk("iss_unexpected", 32'd1, 32'd0);
        else begin
          mon_iss = exp_iss.pop_front();
          chk("iss_phase", {16'h0, cordic_phase}, {16'h0, mon_iss.ph});
          chk("iss_cycle", cyc, mon_iss.due);
        end
      end
      if (resp_valid != '0) begin
        resp_any_cnt++;
        if (resp_valid == 4'b0100) resp2_cnt++;
        if (exp_resp.size() == 0) chk("resp_unexpected", {28'h0, resp_valid}, 32'd0);
        else begin
          mon_resp = exp_resp.pop_front();
          chk("resp_onehot", {28'h0, resp_valid}, {28'h0, mon_resp.oh});
          chk("resp_sincos", resp_sincos, mon_resp.sc);
          chk("resp_cycle", cyc, mon_resp.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phase(input int i, input logic [17:0] v);
    req_phase[18*i +: 18] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_iss.delete();
    exp_resp.delete();
    step();
    rst = 1'b0;
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_phase = '0;
    foreach (cm_p[i]) cm_p[i] = '0;
    repeat (3) step();
    chk("ready_in_reset", {28'h0, req_ready}, 32'd0);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_resp_valid", {28'h0, resp_valid}, 32'd0);
    chk("rst_resp_sincos", resp_sincos, 32'd0);
    chk("rst_phase_valid", {31'h0, cordic_phase_valid}, 32'd0);
    chk("rst_phase", {16'h0, cordic_phase}, 32'd0);
    chk("rst_seq_err", {31'h0, seq_err}, 32'd0);

    // Single issue of phase 0 from requester 0.
    step();
    req_valid = 4'b0001;
    set_phase(0, 18'h0);
    #1;
    chk("t1_ready", {28'h0, req_ready}, 32'd1);
    t0 = cyc;
    step();
    req_valid = '0;
    chk("t1_phase_valid", {31'h0, cordic_phase_valid}, 32'd1);
    chk("t1_latency_cycle", cyc, t0 + 1);
    repeat (LAT + 1) step();
    chk("t1_resp_valid", {28'h0, resp_valid}, 32'd1);
    chk("t1_resp_sincos", resp_sincos, 32'h0000_4000);
    repeat (5) step();

    // All requesters continuously valid: rotation 0,1,2,3,0,1,2,3.
    do_reset();
    repeat (2) step();
    for (int c = 0; c < 8; c++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) set_phase(i, 18'(32'h100 + i * 32'h400 + c * 32'h40));
      #1;
      chk("t2_grant", {28'h0, req_ready}, 32'(1 << (c % 4)));
      step();
    end
    req_valid = '0;
    repeat (30) step();

    // Requester 2 alone, back-to-back.
    resp2_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      req_valid = 4'b0100;
      set_phase(2, 18'(32'h1000 + k * 16));
      #1;
      chk("t3_ready", {28'h0, req_ready}, 32'h4);
      step();
    end
    req_valid = '0;
    repeat (30) step();
    chk("t3_resp_count", resp2_cnt, 32'd30);

    // Out-of-range phases through the optional wrap stage.
    req_valid = 4'b0010;
    set_phase(1, 18'h0D000);
    #1;
    step();
    req_valid = '0;
    chk("t4_wrap_pos", {16'h0, cordic_phase}, {16'h0, EXP_POS});
    step();
    req_valid = 4'b0010;
    set_phase(1, 18'h33000);
    #1;
    step();
    req_valid = '0;
    chk("t4_wrap_neg", {16'h0, cordic_phase}, {16'h0, EXP_NEG});
    repeat (30) step();

    // Reset with five results in flight.
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0001;
      set_phase(0, 18'(k * 32'h200 + 32'h80));
      #1;
      step();
    end
    req_valid = '0;
    repeat (10) step();
    resp_any_cnt = 0;
    do_reset();
    repeat (45) step();
    chk("t5_no_resp_after_rst", resp_any_cnt, 32'd0);
    chk("t5_seq_err", {31'h0, seq_err}, 32'd0);

    // Spurious core output with nothing pending.
    force_dv = 1'b1;
    #1;
    step();
    force_dv = 1'b0;
    chk("t6_seq_err_set", {31'h0, seq_err}, 32'd1);
    repeat (5) step();
    chk("t6_seq_err_sticky", {31'h0, seq_err}, 32'd1);
    do_reset();
    chk("t6_seq_err_cleared", {31'h0, seq_err}, 32'd0);

    repeat (3) step();
    chk("sb_iss_drained", exp_iss.size(), 32'd0);
    chk("sb_resp_drained", exp_resp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one pipelined CORDIC sin/cos core between up to N_REQ requesters, such as the Co/Cg gradient channels and future visualizer effects, so that only one `cordic_sincos_pipelined` instance is needed. Requests are granted by round-robin arbitration, and each phase is tagged with its requester's index. The tag travels through a shift register that matches the CORDIC latency, and each result is returned as a one-cycle pulse to the requester that issued it. The block sits between the pixel-colour generators and the CORDIC core, and drives the core's AXI-stream phase/dout ports directly.

## Interface
- N_REQ, 4: number of requesters (2..8); TAG_W = $clog2(N_REQ)
- LATENCY, 20: CORDIC core latency in cycles, from phase-valid input to dout output
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_phase  in  N_REQ*18  per-requester signed angle, Q5.13 (requester i at [18i+17:18i])
- resp_valid  out  N_REQ  one-hot result pulse
- resp_sincos  out  32  {sin, cos}, each signed Q2.14, shared by all requesters
- cordic_phase_valid  out  1  to core s_axis_phase_tvalid
- cordic_phase  out  16  to core s_axis_phase_tdata, signed Q3.13
- cordic_dout_valid  in  1  from core m_axis_dout_tvalid
- cordic_dout  in  32  from core m_axis_dout_tdata
- seq_err  out  1  sticky: core output valid disagreed with tag pipeline

## Operation
- Grant (combinational): search starts at `rr_ptr` and picks the first requester i with req_valid[i]. That requester gets req_ready[i] = 1; all other ready bits are 0. If no request is valid, req_ready = 0.
- The requester must hold req_valid and req_phase until the transfer completes. A transfer completes when req_valid[i] && req_ready[i].
- On a grant to requester i:
  - `rr_ptr` <= (i+1) mod N_REQ.
  - The issue register loads the corrected phase, cordic_phase_valid <= 1, and the issue tag <= i.
- With no grant, cordic_phase_valid <= 0 and cordic_phase holds its value.
- Tag pipeline: LATENCY stages of {valid, tag}. Its input is the issue register; it advances every cycle and is never stalled.
- Result stage: when the tag pipeline output valid is 1:
  - resp_sincos <= cordic_dout.
  - resp_valid <= one-hot(tag).
  - Otherwise resp_valid <= 0 and resp_sincos holds its value.
- The core has no backpressure, so responses cannot be refused. The consumer must capture the result in the pulse cycle.
- seq_err is set when, at the result stage, cordic_dout_valid != the tag pipeline output valid. It stays set until reset.
- Phase correction: see Configuration. The result is always truncated to 16 bits for cordic_phase.

## Timing
- Throughput: one issue per cycle, sustained. This holds whether one requester or several are active.
- Latency: a transfer accepted in cycle T has cordic_phase_valid = 1 in T+1, and resp_valid pulses in T+1+LATENCY+1. The total is LATENCY+2 cycles (22 with default parameters).
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles, in ascending index order starting from rr_ptr.
- Reset values: req_ready = 0 while rst is high. After reset:
  - resp_valid = 0, resp_sincos = 0.
  - cordic_phase_valid = 0, cordic_phase = 0.
  - seq_err = 0, rr_ptr = 0.
  - All tag pipeline valid bits = 0.
- Reset mid-operation: in-flight tags are discarded. Any core output arriving after reset produces no resp_valid. cordic_dout_valid = 1 during the first LATENCY cycles after reset sets seq_err only when seq_err checking is armed, and checking arms LATENCY cycles after reset release.
- rr_ptr wraps from N_REQ-1 to 0.

## Configuration
- CORDIC_ARB_ANGLE_WRAP_EN defined: the issue stage applies a single ±2π correction, with π = 16'h6487 (Q3.13):
  - phase > π: subtract 2π.
  - phase < −π: add 2π.
  - otherwise: pass unchanged.
  - Accepted input range is (−3π, 3π).
- CORDIC_ARB_ANGLE_WRAP_EN undefined: req_phase[15:0] is passed unchanged. The requester guarantees the angle is already in [−π, π]. Latency is identical in both builds.

## Test plan
- Reset, then requester 0 alone issues phase 0 → cordic_phase_valid = 1 at T+1. resp_valid = 4'b0001 at T+22, with resp_sincos equal to the core model output {0x0000, 0x4000}.
- All 4 requesters continuously valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Each response returns one-hot to the correct requester, 22 cycles after its grant.
- Requester 2 alone, back-to-back for 30 cycles → req_ready[2] = 1 every cycle, and 30 consecutive resp_valid = 4'b0100 pulses.
- Phase 18'h0D000 (≈6.5) with CORDIC_ARB_ANGLE_WRAP_EN defined → cordic_phase = 16'h0D000 − 16'hC90E. With the macro undefined → cordic_phase = 16'hD000.
- rst asserted for 1 cycle, 10 cycles after 5 issues → no resp_valid for those issues, and seq_err = 0.
- Core model forced to emit dout_valid with no tag pending → seq_err = 1 the next cycle, and it stays 1 until rst.
